// File: rtl/mux_16bit_pkg.sv
// Shared constants for the writeback-select mux: default widths and select encodings.
package mux_16bit_pkg;

  localparam int DATA_W    = 16;
  localparam int CNT_W_DEF = 8;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/mux_toggle_mon.sv
// Debug monitor for the writeback select: registered SEL and a saturating count of SEL transitions.
module mux_toggle_mon
  import mux_16bit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  output logic             sel_q,
  output logic [CNT_W-1:0] tog_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic toggle;

  // sel_q clears to the ALU encoding, so SEL=MEM right after reset counts as a toggle
  assign toggle = (sel != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= SEL_ALU;
      tog_cnt <= '0;
    end else begin
      sel_q <= sel;
      if (toggle && (tog_cnt != CNT_MAX)) begin
        tog_cnt <= tog_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_16bit.sv
// Memory-stage writeback select: OUT = SEL ? IN1 (memory) : IN0 (ALU), plus parity and toggle monitor.
// Define MUX_16BIT_REG_OUT_EN to register OUT (one-cycle latency, cleared by rst).
module mux_16bit
  import mux_16bit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic             SEL,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_PAR,
  output logic             SEL_Q,
  output logic [CNT_W-1:0] TOG_CNT
);

  logic [WIDTH-1:0] mux_sel;

  assign mux_sel = (SEL == SEL_MEM) ? IN1 : IN0;

`ifdef MUX_16BIT_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT <= '0;
    end else begin
      OUT <= mux_sel;
    end
  end
`else
  assign OUT = mux_sel;
`endif

  // parity is taken from OUT itself so it carries the same latency in both builds
  assign OUT_PAR = ^OUT;

  mux_toggle_mon #(
    .CNT_W (CNT_W)
  ) u_tog_mon (
    .clk     (clk),
    .rst     (rst),
    .sel     (SEL),
    .sel_q   (SEL_Q),
    .tog_cnt (TOG_CNT)
  );

endmodule

// File: tb/tb_mux_16bit.sv
// Self-checking bench for mux_16bit: per-cycle model comparison plus directed literal checks.
// Covers both builds; define MUX_16BIT_REG_OUT_EN to check the registered-output variant.
module tb_mux_16bit;

  localparam int W   = 16;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  IN0, IN1;
  logic          SEL;
  logic [W-1:0]  OUT;
  logic          OUT_PAR;
  logic          SEL_Q;
  logic [CW-1:0] TOG_CNT;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // reference state
  int           m_toggles;
  logic         m_sel_q;
  logic [W-1:0] m_out_r;

  mux_16bit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .IN0     (IN0),
    .IN1     (IN1),
    .SEL     (SEL),
    .OUT     (OUT),
    .OUT_PAR (OUT_PAR),
    .SEL_Q   (SEL_Q),
    .TOG_CNT (TOG_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_out();
`ifdef MUX_16BIT_REG_OUT_EN
    return m_out_r;
`else
    return SEL ? IN1 : IN0;
`endif
  endfunction

  function automatic int exp_cnt();
    return (m_toggles > SAT) ? SAT : m_toggles;
  endfunction

  // model: total toggle count since reset, clipped when compared
  always @(posedge clk) begin
    if (rst) begin
      m_toggles = 0;
      m_sel_q   = 1'b0;
      m_out_r   = '0;
    end else begin
      if (SEL != m_sel_q) m_toggles = m_toggles + 1;
      m_sel_q = SEL;
      m_out_r = SEL ? IN1 : IN0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cyc_out",     32'(OUT),     32'(exp_out()));
      chk("cyc_par",     32'(OUT_PAR), 32'(^exp_out()));
      chk("cyc_sel_q",   32'(SEL_Q),   32'(m_sel_q));
      chk("cyc_tog_cnt", 32'(TOG_CNT), 32'(exp_cnt()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] sweep [3];
    sweep[0] = 16'h0000; sweep[1] = 16'hFFFF; sweep[2] = 16'h5A5A;

    rst = 1'b1; IN0 = '0; IN1 = '0; SEL = 1'b0;
    tick(); tick();
    mon_en = 1'b1;
    chk("rst_sel_q", 32'(SEL_Q), 32'd0);
    chk("rst_cnt",   32'(TOG_CNT), 32'd0);
`ifdef MUX_16BIT_REG_OUT_EN
    chk("rst_out_reg", 32'(OUT), 32'd0);
`endif

    // latency of OUT
    rst = 1'b0; IN0 = 16'h00FF; IN1 = 16'h0000; SEL = 1'b0;
    #1;
`ifdef MUX_16BIT_REG_OUT_EN
    chk("lat_before_edge", 32'(OUT), 32'h0000);
`else
    chk("lat_comb", 32'(OUT), 32'h00FF);
`endif
    tick();
    chk("lat_after_edge", 32'(OUT), 32'h00FF);

    // toggle pattern 1,0,1,1
    SEL = 1'b1; tick();
    SEL = 1'b0; tick();
    SEL = 1'b1; tick();
    SEL = 1'b1; tick();
    chk("pat_cnt",   32'(TOG_CNT), 32'd3);
    chk("pat_sel_q", 32'(SEL_Q),   32'd1);

    // basic select
    IN0 = 16'h1234; IN1 = 16'hABCD; SEL = 1'b0; tick();
    chk("sel0_out", 32'(OUT),     32'h1234);
    chk("sel0_par", 32'(OUT_PAR), 32'd1);
    SEL = 1'b1; tick();
    chk("sel1_out", 32'(OUT),     32'hABCD);
    chk("sel1_par", 32'(OUT_PAR), 32'd0);
    chk("sel_cnt",  32'(TOG_CNT), 32'd5);

    // isolation sweeps
    SEL = 1'b0; IN0 = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      IN1 = sweep[i]; tick();
      chk("iso_sel0", 32'(OUT), 32'h1234);
    end
    SEL = 1'b1; IN1 = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      IN0 = sweep[i]; tick();
      chk("iso_sel1", 32'(OUT), 32'hABCD);
    end

    // saturation
    rst = 1'b1; SEL = 1'b0; tick();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      SEL = ~SEL; tick();
    end
    chk("sat_cnt", 32'(TOG_CNT), 32'(SAT));
    for (int i = 0; i < 4; i++) tick();
    chk("sat_hold", 32'(TOG_CNT), 32'(SAT));
    IN0 = 16'hBEEF; rst = 1'b1; tick();
    chk("sat_rst_cnt", 32'(TOG_CNT), 32'd0);
`ifdef MUX_16BIT_REG_OUT_EN
    chk("rst_mid_out", 32'(OUT), 32'd0);
`else
    chk("rst_mid_out", 32'(OUT), SEL ? 32'(IN1) : 32'h0000BEEF);
`endif

    // reset priority over a simultaneous toggle
    rst = 1'b0; SEL = 1'b0; tick(); tick();
    chk("prio_pre_sel_q", 32'(SEL_Q), 32'd0);
    rst = 1'b1; SEL = 1'b1; tick();
    chk("prio_cnt",   32'(TOG_CNT), 32'd0);
    chk("prio_sel_q", 32'(SEL_Q),   32'd0);
    rst = 1'b0; tick();
    chk("post_prio_cnt", 32'(TOG_CNT), 32'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
